// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit.
// Timeout support is enabled by defining MEM_ACCESS_TIMEOUT_EN.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts ACCESS cycles without an acknowledge.
// Only instantiated when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_timeout_cnt
  import mem_access_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High during the last ACCESS cycle the memory is given to respond.
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// EX->MEM->WB access unit: issues data-memory requests and retires.
// Define MEM_ACCESS_TIMEOUT_EN to enable the access timeout.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic        MemToReg_i,
  input  logic        RegWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  state_t     state;
  logic [4:0] rd_q;
  logic       m2r_q;
  logic       rw_q;
  logic       xfer;
  logic       mem_op;
  logic       expired;

  assign stall_o = (state != IDLE);
  assign xfer    = valid_i & ~stall_o;
  assign mem_op  = MemRd_i | MemWr_i;

`ifdef MEM_ACCESS_TIMEOUT_EN
  mem_timeout_cnt u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (xfer & mem_op),
    .inc     ((state == ACCESS) & ~dmem_ack_i),
    .expired (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= (state == ACCESS) & expired & ~dmem_ack_i;
    end
  end
`else
  assign expired = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      rd_q         <= '0;
      m2r_q        <= 1'b0;
      rw_q         <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer && mem_op) begin
            state        <= ACCESS;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= MemWr_i & ~MemRd_i;
            dmem_addr_o  <= addr_i;
            dmem_wdata_o <= wdata_i;
            rd_q         <= rd_i;
            m2r_q        <= MemToReg_i;
            rw_q         <= RegWrite_i;
          end else if (xfer) begin
            wb_valid_o <= 1'b1;
            wb_we_o    <= RegWrite_i;
            wb_rd_o    <= rd_i;
            wb_data_o  <= addr_i;
          end
        end
        ACCESS: begin
          if (dmem_ack_i || expired) begin
            state      <= RESP;
            dmem_req_o <= 1'b0;
            dmem_we_o  <= 1'b0;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= rd_q;
            // Stores and timed-out accesses never write the register file.
            wb_we_o    <= rw_q & ~dmem_we_o & dmem_ack_i;
            wb_data_o  <= (m2r_q && dmem_ack_i) ? dmem_rdata_i
                                                : dmem_addr_o;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit.
// Timeout cases run only when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        MemRd_i;
  logic        MemWr_i;
  logic        MemToReg_i;
  logic        RegWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_we_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_access_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .MemRd_i      (MemRd_i),
    .MemWr_i      (MemWr_i),
    .MemToReg_i   (MemToReg_i),
    .RegWrite_i   (RegWrite_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rd_i         (rd_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_we_o      (wb_we_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction for exactly one cycle, then scramble inputs.
  task automatic issue(input bit mrd, input bit mwr,
                       input bit m2r, input bit rw,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] r);
    check("stall_before_issue", stall_o, 0);
    valid_i      = 1'b1;
    MemRd_i      = mrd;
    MemWr_i      = mwr;
    MemToReg_i   = m2r;
    RegWrite_i   = rw;
    addr_i       = a;
    wdata_i      = wd;
    rd_i         = r;
    dmem_ack_i   = 1'($urandom % 2);
    dmem_rdata_i = $urandom;
    @(negedge clk_i);
    valid_i      = 1'b0;
    MemRd_i      = 1'($urandom % 2);
    MemWr_i      = 1'($urandom % 2);
    MemToReg_i   = 1'($urandom % 2);
    RegWrite_i   = 1'($urandom % 2);
    addr_i       = $urandom;
    wdata_i      = $urandom;
    rd_i         = 5'($urandom);
    dmem_ack_i   = 1'b0;
  endtask

  // Whole instruction lifetime; lat = ACCESS cycles until ack.
  task automatic run_op(input bit mrd, input bit mwr,
                        input bit m2r, input bit rw,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] r, input int lat);
    bit          mem;
    bit          st;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    mem   = mrd | mwr;
    st    = mwr & ~mrd;
    rdata = $urandom;
    issue(mrd, mwr, m2r, rw, a, wd, r);
    if (mem) begin
      for (int k = 1; k <= lat; k++) begin
        check("req_access", dmem_req_o, 1);
        check("addr_access", dmem_addr_o, a);
        check("we_access", dmem_we_o, st);
        check("wdata_access", dmem_wdata_o, wd);
        check("stall_access", stall_o, 1);
        check("wb_valid_access", wb_valid_o, 0);
        dmem_ack_i   = (k == lat);
        dmem_rdata_i = (k == lat) ? rdata : $urandom;
        @(negedge clk_i);
      end
      dmem_ack_i   = 1'($urandom % 2);
      dmem_rdata_i = $urandom;
    end
    exp_data = (mem && m2r) ? rdata : a;
    check("wb_valid", wb_valid_o, 1);
    check("wb_we", wb_we_o, rw & ~st);
    check("wb_rd", wb_rd_o, r);
    check("wb_data", wb_data_o, exp_data);
    check("err_retire", err_o, 0);
    check("stall_retire", stall_o, mem);
    check("req_retire", dmem_req_o, 0);
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    check("wb_valid_pulse", wb_valid_o, 0);
    check("wb_data_hold", wb_data_o, exp_data);
    check("stall_after", stall_o, 0);
  endtask

  initial begin
    rst_i        = 1'b1;
    valid_i      = 1'b0;
    MemRd_i      = 1'b0;
    MemWr_i      = 1'b0;
    MemToReg_i   = 1'b0;
    RegWrite_i   = 1'b0;
    addr_i       = '0;
    wdata_i      = '0;
    rd_i         = '0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = '0;
    repeat (2) @(negedge clk_i);

    check("rst_stall", stall_o, 0);
    check("rst_req", dmem_req_o, 0);
    check("rst_we", dmem_we_o, 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_wdata", dmem_wdata_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_we", wb_we_o, 0);
    check("rst_wb_rd", wb_rd_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // ALU op, load, store, read+write collision.
    run_op(0, 0, 0, 1, 32'h42, 32'h0, 5'd5, 0);
    run_op(1, 0, 1, 1, 32'h100, 32'h0, 5'd7, 3);
    run_op(0, 1, 0, 0, 32'h200, 32'h1234, 5'd0, 2);
    run_op(1, 1, 1, 1, 32'h300, 32'h5555, 5'd9, 1);
    run_op(0, 1, 0, 1, 32'h204, 32'h77, 5'd3, 1);

    // Reset on the second ACCESS cycle discards the load.
    issue(1, 0, 1, 1, 32'h400, 32'h0, 5'd12);
    check("rst_case_req1", dmem_req_o, 1);
    @(negedge clk_i);
    check("rst_case_req2", dmem_req_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_case_req_drop", dmem_req_o, 0);
    check("rst_case_stall", stall_o, 0);
    check("rst_case_wb_valid", wb_valid_o, 0);
    for (int k = 0; k < 3; k++) begin
      dmem_ack_i = 1'($urandom % 2);
      @(negedge clk_i);
      check("rst_case_no_retire", wb_valid_o, 0);
    end
    dmem_ack_i = 1'b0;
    run_op(0, 0, 0, 1, 32'h99, 32'h0, 5'd4, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    issue(1, 0, 1, 1, 32'h500, 32'h0, 5'd8);
    for (int k = 1; k <= 16; k++) begin
      check("to_req", dmem_req_o, 1);
      check("to_err_early", err_o, 0);
      @(negedge clk_i);
    end
    check("to_req_drop", dmem_req_o, 0);
    check("to_err", err_o, 1);
    check("to_wb_valid", wb_valid_o, 1);
    check("to_wb_we", wb_we_o, 0);
    @(negedge clk_i);
    check("to_err_pulse", err_o, 0);
    check("to_wb_pulse", wb_valid_o, 0);
    run_op(1, 0, 1, 1, 32'h504, 32'h0, 5'd9, 16);
`endif

    for (int i = 0; i < 200; i++) begin
      run_op(1'($urandom % 2), 1'($urandom % 2),
             1'($urandom % 2), 1'($urandom % 2),
             $urandom, $urandom, 5'($urandom),
             int'($urandom_range(1, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  EX-stage instruction valid
- MemRd_i, MemWr_i, MemToReg_i, RegWrite_i  in  1 each  decoded control for the instruction
- addr_i  in  32  ALU result, used as memory address
- wdata_i  in  32  store data
- rd_i  in  5  destination register
- stall_o  out  1  upstream must hold its current instruction
- dmem_req_o  out  1  data-memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  memory address
- dmem_wdata_o  out  32  memory write data
- dmem_ack_i  in  1  memory acknowledge
- dmem_rdata_i  in  32  read data, valid with dmem_ack_i
- wb_valid_o  out  1  one-cycle retire pulse
- wb_we_o  out  1  register-file write enable
- wb_rd_o  out  5  write-back register
- wb_data_o  out  32  write-back data
- err_o  out  1  one-cycle access-error pulse

Function
REQ-002 A transfer SHALL occur on a rising edge where valid_i=1 and stall_o=0.
REQ-003 stall_o SHALL equal (state != IDLE), decoded combinationally from the state register.
REQ-004 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-005 IDLE, transfer with MemRd_i=0 and MemWr_i=0: remain IDLE; next cycle wb_valid_o=1, wb_we_o=RegWrite_i, wb_rd_o=rd_i, wb_data_o=addr_i (latency 1).
REQ-006 IDLE, transfer with MemRd_i or MemWr_i set: latch addr_i, wdata_i, rd_i and the control bits, then go to ACCESS.
REQ-007 If MemRd_i=MemWr_i=1, the access SHALL be a read; the write is suppressed.
REQ-008 ACCESS: dmem_req_o=1; dmem_addr_o, dmem_wdata_o and dmem_we_o come from the latched values and stay stable until ack.
- On dmem_ack_i=1: capture dmem_rdata_i, go to RESP.
- dmem_req_o is 0 from the next cycle.
REQ-009 RESP lasts exactly one cycle, then returns to IDLE, with:
- wb_valid_o=1
- wb_rd_o = latched rd
- wb_data_o = captured read data if latched MemToReg, else latched address
- wb_we_o = latched RegWrite AND NOT err
REQ-010 A store SHALL retire in RESP with wb_we_o=0.
REQ-011 Minimum load latency: transfer at edge T, req high in cycle T+1, ack same cycle, wb_valid_o in cycle T+2, next transfer possible at edge T+3.
REQ-012 dmem_ack_i SHALL be ignored in IDLE and RESP.
REQ-013 wb_valid_o and err_o SHALL be single-cycle pulses; the wb_* data outputs hold their last value otherwise.

Reset
REQ-014 While rst_i=1 at a clock edge, the following SHALL be 0 after that edge:
- state (IDLE), stall_o, dmem_req_o, dmem_we_o
- dmem_addr_o, dmem_wdata_o
- wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, err_o
- timeout counter
REQ-015 Reset during ACCESS SHALL drop dmem_req_o at that edge and discard the in-flight instruction with no retire pulse.

Configuration
REQ-016 With MEM_ACCESS_TIMEOUT_EN defined:
- A counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
- If TIMEOUT_CYCLES (16) cycles pass without ack, go to RESP with err_o=1 and wb_we_o=0.
- An ack in the expiry cycle SHALL win, giving a normal completion.
REQ-017 Without MEM_ACCESS_TIMEOUT_EN:
- err_o SHALL be tied 0.
- ACCESS waits indefinitely for ack.
- No counter logic is present.

Structure
REQ-018 Package mem_access_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the TIMEOUT_CYCLES constant and the counter width.
REQ-019 The timeout counter SHALL be a sub-module mem_timeout_cnt, instantiated only under MEM_ACCESS_TIMEOUT_EN.

Verification
REQ-020 ALU op: valid_i=1, RegWrite_i=1, addr_i=0x0000_0042, rd_i=5 -> next cycle wb_valid_o=1, wb_we_o=1, wb_rd_o=5, wb_data_o=0x42, stall_o=0 throughout.
REQ-021 Load: MemRd_i=MemToReg_i=RegWrite_i=1, addr_i=0x100, rd_i=7; ack after 3 cycles with rdata 0xDEADBEEF -> dmem_req_o high 3 cycles, then wb_data_o=0xDEADBEEF, wb_we_o=1, wb_rd_o=7; stall_o high 4 cycles.
REQ-022 Store: MemWr_i=1, addr_i=0x200, wdata_i=0x1234 -> dmem_we_o=1, dmem_wdata_o=0x1234 until ack; retire with wb_we_o=0.
REQ-023 Reset asserted on the 2nd ACCESS cycle -> dmem_req_o=0 next cycle, no wb_valid_o pulse, a later ALU op retires normally.
REQ-024 With MEM_ACCESS_TIMEOUT_EN, load never acked -> dmem_req_o high 16 cycles, then err_o=1 and wb_valid_o=1 with wb_we_o=0; repeat with ack in cycle 16 -> err_o=0.
REQ-025 MemRd_i=MemWr_i=1 -> dmem_we_o=0 for the whole access.
